// File: rtl/apb_pkg.sv
// Shared types and default sizes for the APB requester and its benches.
package apb_pkg;

    localparam int APB_WIDTH      = 8;
    localparam int APB_MEM_DEPTH  = 16;
    localparam int APB_ADDR_WIDTH = $clog2(APB_MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_WIDTH-1:0]      wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer with a one-cycle response.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int WIDTH          = APB_WIDTH,
    parameter int MEM_DEPTH      = APB_MEM_DEPTH,
    parameter int ADDR_WIDTH     = $clog2(MEM_DEPTH),
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic                  pclk_i,
    input  logic                  presetn_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [WIDTH-1:0]      cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [WIDTH-1:0]      rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [WIDTH-1:0]      pwdata_o,
    input  logic [WIDTH-1:0]      prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    apb_state_e            state_reg;
    logic                  busy_reg;
    logic                  psel_reg;
    logic                  penable_reg;
    logic                  pwrite_reg;
    logic [ADDR_WIDTH-1:0] paddr_reg;
    logic [WIDTH-1:0]      pwdata_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_err_reg;
    logic [WIDTH-1:0]      rsp_rdata_reg;
    logic                  timeout_hit;
    logic                  complete;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] access_cnt_reg;

    // Counts ACCESS cycles already spent; value N-1 means this is the Nth cycle.
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            access_cnt_reg <= '0;
        end else if (state_reg == ACCESS && !complete) begin
            access_cnt_reg <= access_cnt_reg + CNT_W'(1);
        end else begin
            access_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (access_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign complete = (state_reg == ACCESS) && (pready_i || timeout_hit);

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cmd_valid_i) begin
                        pwrite_reg <= cmd_write_i;
                        paddr_reg  <= cmd_addr_i;
                        pwdata_reg <= cmd_wdata_i;
                        psel_reg   <= 1'b1;
                        busy_reg   <= 1'b1;
                        state_reg  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_reg <= 1'b1;
                    state_reg   <= ACCESS;
                end
                ACCESS: begin
                    if (complete) begin
                        // A timeout (no pready) reports an error with zero data.
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= pready_i ? pslverr_i : 1'b1;
                        rsp_rdata_reg <= (pready_i && !pwrite_reg) ? prdata_i : '0;
                        psel_reg      <= 1'b0;
                        penable_reg   <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    psel_reg    <= 1'b0;
                    penable_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    // Gated by reset so the port reads 0 while held in reset and 1 as soon as it is released.
    assign cmd_ready_o = presetn_i & ~busy_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_rdata_o = rsp_rdata_reg;
    assign rsp_err_o   = rsp_err_reg;
    assign psel_o      = psel_reg;
    assign penable_o   = penable_reg;
    assign pwrite_o    = pwrite_reg;
    assign paddr_o     = paddr_reg;
    assign pwdata_o    = pwdata_reg;

endmodule
